// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in, serial-out frame transmitter.
// Frame format on tx_out: start bit (0), DATA_W payload bits LSB first, stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles. Words are taken over a
// valid/ready handshake that is only open while the line is idle.
// All outputs are driven straight from flops; no input reaches an output
// combinationally.

module piso_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    // Counter widths. The baud counter keeps at least one bit so that
    // CLKS_PER_BIT=1 still elaborates; in that case it simply stays at zero.
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: the last payload bit index and the last cycle of a bit.
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_next;
    logic [BAUD_W-1:0]   baud_cnt_reg;
    logic [BAUD_W-1:0]   baud_cnt_next;
    logic                out_reg;
    logic                out_next;
    logic                ready_reg;
    logic                ready_next;
    logic                busy_reg;
    logic                busy_next;
    logic                done_reg;
    logic                done_next;

    // High on the last cycle of the current bit period; the state advances here.
    logic                bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    // Register all state and outputs; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
            out_reg      <= 1'b1;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            baud_cnt_reg <= baud_cnt_next;
            out_reg      <= out_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and next-output logic; every value holds unless a case below
    // changes it, except tx_done which is a single-cycle pulse.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        baud_cnt_next = baud_cnt_reg;
        out_next      = out_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                // ready_reg is high throughout IDLE, including the tx_done
                // cycle, so a waiting word starts the next frame immediately.
                if (tx_valid && ready_reg) begin
                    shift_next    = tx_data;
                    state_next    = START;
                    out_next      = 1'b0;
                    busy_next     = 1'b1;
                    ready_next    = 1'b0;
                    baud_cnt_next = '0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next    = DATA;
                    out_next      = shift_reg[0];
                    bit_cnt_next  = '0;
                    baud_cnt_next = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        // Last payload bit has had its full period.
                        state_next = STOP;
                        out_next   = 1'b1;
                    end else begin
                        // The bit that becomes bit 0 after the shift is
                        // shift_reg[1]; drive it in the same edge.
                        shift_next   = shift_reg >> 1;
                        out_next     = shift_reg[1];
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_next    = IDLE;
                    busy_next     = 1'b0;
                    ready_next    = 1'b1;
                    done_next     = 1'b1;
                    baud_cnt_next = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                out_next   = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign tx_out   = out_reg;
    assign tx_ready = ready_reg;
    assign tx_busy  = busy_reg;
    assign tx_done  = done_reg;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: one instance at the default size (8 bits, 4 clocks
// per bit) and one at 4 bits with 1 clock per bit. A frame-level model is
// compared against both instances on every falling clock edge, and directed
// sequences pin hand-computed waveforms.
// Inputs change 2 time units after a rising edge; outputs are sampled there
// by the directed code and on the falling edge by the model checker.

module tb_piso_serial_tx;

    localparam int DW0  = 8;
    localparam int CPB0 = 4;
    localparam int DW1  = 4;
    localparam int CPB1 = 1;

    logic       clk;
    logic       rst_n;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_out;
    logic       s_busy;
    logic       s_done;

    int tests_run    = 0;
    int tests_failed = 0;

    piso_serial_tx #(.DATA_W(DW0), .CLKS_PER_BIT(CPB0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    piso_serial_tx #(.DATA_W(DW1), .CLKS_PER_BIT(CPB1)) dut_narrow (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (s_data),
        .tx_valid (s_valid),
        .tx_ready (s_ready),
        .tx_out   (s_out),
        .tx_busy  (s_busy),
        .tx_done  (s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line value of frame bit idx: 0 = start, 1..dw = payload LSB first, dw+1 = stop.
    function automatic logic frame_bit(input int dw, input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx > dw) return 1'b1;
        return d[idx-1];
    endfunction

    // Model state per instance: m_k = cycle index inside the current frame
    // (-1 when idle), m_done = this idle cycle is the completion cycle.
    int         m_k    [2];
    logic       m_done [2];
    logic [7:0] m_d    [2];

    // Model checker: compare, then advance using the inputs the next rising edge sees.
    initial begin
        int         fl;
        int         cpb;
        int         dw;
        logic       v;
        logic [7:0] d;
        logic       eo;
        for (int i = 0; i < 2; i++) begin
            m_k[i]    = -1;
            m_done[i] = 1'b0;
            m_d[i]    = 8'h00;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_k[i]    = -1;
                    m_done[i] = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                cpb = (i == 0) ? CPB0 : CPB1;
                dw  = (i == 0) ? DW0 : DW1;
                fl  = (dw + 2) * cpb;
                eo  = (m_k[i] < 0) ? 1'b1 : frame_bit(dw, m_d[i], m_k[i] / cpb);
                if (i == 0) begin
                    chk("model_out",   tx_out,   eo);
                    chk("model_busy",  tx_busy,  m_k[i] >= 0);
                    chk("model_ready", tx_ready, m_k[i] < 0);
                    chk("model_done",  tx_done,  m_done[i]);
                    v = tx_valid;
                    d = tx_data;
                end else begin
                    chk("model_n_out",   s_out,   eo);
                    chk("model_n_busy",  s_busy,  m_k[i] >= 0);
                    chk("model_n_ready", s_ready, m_k[i] < 0);
                    chk("model_n_done",  s_done,  m_done[i]);
                    v = s_valid;
                    d = {4'h0, s_data};
                end
                if (rst_n) begin
                    if (m_k[i] >= 0) begin
                        m_k[i]++;
                        if (m_k[i] == fl) begin
                            m_k[i]    = -1;
                            m_done[i] = 1'b1;
                        end else begin
                            m_done[i] = 1'b0;
                        end
                    end else begin
                        m_done[i] = 1'b0;
                        if (v) begin
                            m_k[i] = 0;
                            m_d[i] = d;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Send one word on the wide instance and check its 40-cycle waveform
    // against a hand-written 10-bit frame pattern (bit 0 = start bit).
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic [9:0] pat, input bit inject);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        tick();
        tx_valid = 1'b1;
        tx_data  = d;
        for (int j = 0; j < 45; j++) begin
            tick();
            chk({name, "_out"}, tx_out, (j < 40) ? pat[j/4] : 1'b1);
            if (tx_busy) busy_n++;
            if (tx_done) begin
                done_n++;
                done_at = j;
            end
            if (j == 0) tx_valid = 1'b0;
            if (inject && j == 10) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (inject && j == 12) begin
                tx_valid = 1'b0;
                tx_data  = 8'h55;
            end
        end
        chk({name, "_busy_cycles"}, busy_n, 40);
        chk({name, "_done_count"}, done_n, 1);
        chk({name, "_done_cycle"}, done_at, 40);
    endtask

    initial begin
        int         busy_n;
        int         done_n;
        int         last_busy;
        logic       exp_o;
        logic [5:0] pat6;

        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s_valid  = 1'b0;
        s_data   = 4'h0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_out",   tx_out,   1'b1);
        chk("reset_ready", tx_ready, 1'b1);
        chk("reset_busy",  tx_busy,  1'b0);
        chk("reset_done",  tx_done,  1'b0);
        rst_n = 1'b1;

        // Idle line with tx_valid low for 100 cycles.
        for (int j = 0; j < 100; j++) begin
            tick();
            chk("idle_out",  tx_out,  1'b1);
            chk("idle_busy", tx_busy, 1'b0);
            chk("idle_done", tx_done, 1'b0);
        end

        // Single frame 0xA5: 0, 1,0,1,0,0,1,0,1, 1.
        run_frame("a5", 8'hA5, 10'b1101001010, 1'b0);
        repeat (2) tick();

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        busy_n    = 0;
        done_n    = 0;
        last_busy = -1;
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        for (int j = 0; j < 86; j++) begin
            tick();
            exp_o = (j < 36) ? 1'b0 : (j < 41) ? 1'b1 : (j < 45) ? 1'b0 : 1'b1;
            chk("b2b_out",  tx_out,  exp_o);
            chk("b2b_done", tx_done, (j == 40) || (j == 81));
            if (tx_busy) begin
                busy_n++;
                last_busy = j;
            end
            if (tx_done) done_n++;
            if (j == 0) tx_data = 8'hFF;
            if (j == 41) tx_valid = 1'b0;
        end
        chk("b2b_busy_cycles", busy_n, 80);
        chk("b2b_done_count", done_n, 2);
        chk("b2b_span", last_busy + 1, 81);
        repeat (2) tick();

        // 0x3C with a stray valid and data change mid-frame.
        run_frame("3c", 8'h3C, 10'b1001111000, 1'b1);
        repeat (2) tick();

        // Asynchronous reset during the 4th data bit of 0xF0 (that bit is 0).
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        for (int j = 0; j < 18; j++) begin
            tick();
            if (j == 0) tx_valid = 1'b0;
        end
        chk("arst_pre_out", tx_out, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_out",   tx_out,   1'b1);
        chk("arst_ready", tx_ready, 1'b1);
        chk("arst_busy",  tx_busy,  1'b0);
        chk("arst_done",  tx_done,  1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("arst_hold_done", tx_done, 1'b0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("arst_after_done", tx_done, 1'b0);
        end
        run_frame("post_rst_81", 8'h81, 10'b1100000010, 1'b0);

        // Narrow instance: 4'b1010 gives 0,0,1,0,1,1 one cycle each.
        pat6 = 6'b110100;
        tick();
        s_valid = 1'b1;
        s_data  = 4'b1010;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("narrow_out",  s_out,  (j < 6) ? pat6[j] : 1'b1);
            chk("narrow_busy", s_busy, j < 6);
            chk("narrow_done", s_done, j == 6);
            if (j == 0) s_valid = 1'b0;
        end

        // Random traffic on both instances with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            s_valid  = ($urandom_range(0, 2) == 0);
            s_data   = 4'($urandom);
        end
        tick();
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        s_valid  = 1'b0;
        repeat (50) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in, serial-out frame transmitter. Drives the single-bit serial line that our D-type storage and shift-register receivers sample.
- Accepts a DATA_W-bit word through a valid/ready handshake.
- Serialises each word as one start bit (0), DATA_W data bits sent LSB first, and one stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.

Parameters:
- DATA_W, 8: payload width in bits. Must be 2 or more.
- CLKS_PER_BIT, 4: clock cycles per serial bit. Must be 1 or more.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- tx_data, input, DATA_W: word to send. Sampled only on the accept edge.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: block can accept a word.
- tx_out, output, 1: serial line. Idles high.
- tx_busy, output, 1: a frame is in progress (START, DATA or STOP).
- tx_done, output, 1: one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset values: state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, shift register=0, bit counter=0, baud counter=0.
- Registered outputs: all outputs come from flops. There is no combinational path from any input to any output.
- States: IDLE, START, DATA, STOP.
- Accept: a word is accepted on a rising edge where tx_valid=1 and tx_ready=1. tx_ready=1 only in IDLE.
- On the accept edge:
  - tx_data is copied into the shift register.
  - state becomes START, tx_out=0, tx_busy=1, tx_ready=0.
  - baud counter is cleared.
- Bit timing:
  - The baud counter counts 0 to CLKS_PER_BIT-1.
  - Each state holds its line value for exactly CLKS_PER_BIT cycles.
  - A state advances on the edge where the baud counter equals CLKS_PER_BIT-1. That same edge clears the counter.
- START -> DATA: tx_out = shift register bit 0. Bit counter = 0.
- DATA:
  - On each bit boundary, shift the register right by one, drive the new bit 0 onto tx_out, and increment the bit counter.
  - After bit DATA_W-1 has been held its full period, go to STOP with tx_out=1.
- STOP -> IDLE, at the end of the stop period:
  - tx_busy=0, tx_ready=1, tx_done=1 for exactly one cycle. tx_out stays 1.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles of tx_busy=1, followed by at least one IDLE cycle. That IDLE cycle is the tx_done cycle.
- Back-to-back: if tx_valid=1 during the tx_done cycle, the next word is accepted on that edge. The next start bit then begins immediately, so the line stays high for exactly one cycle between frames.
- Ignored inputs:
  - tx_valid while not ready is ignored. There is no queuing, and tx_done does not change.
  - tx_data changes after the accept edge have no effect on the frame in progress.
- Reset during a frame:
  - tx_out returns to 1 immediately, without waiting for a clock edge. All state goes to the reset values.
  - No tx_done pulse is produced. The partial frame is lost.
  - After rst_n is released, the first valid word is accepted normally.
- CLKS_PER_BIT=1: the baud counter is unused (its width is at least 1 bit). Each state lasts exactly one cycle, giving a frame of DATA_W+2 cycles.
- Counter widths:
  - bit counter: $clog2(DATA_W) bits.
  - baud counter: max(1, $clog2(CLKS_PER_BIT)) bits.
  - Neither counter may wrap inside a state.

Test Plan:
1. Default parameters. After reset, check tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. Pulse tx_valid for one cycle with tx_data=8'hA5.
   - Required tx_out sequence, each value held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
   - tx_busy=1 for exactly 40 cycles, then tx_done=1 for one cycle.
2. Hold tx_valid=1 and send 8'h00 then 8'hFF back-to-back.
   - Second start bit begins on the cycle after tx_done.
   - Line is high for exactly 1 cycle between the frames.
   - Total from first start bit to second stop end = 81 cycles.
3. While sending 8'h3C, assert tx_valid with tx_data=8'hFF at cycle 10, and also change tx_data.
   - Transmitted bits still match 8'h3C (LSB first: 0,0,1,1,1,1,0,0).
   - Exactly one tx_done pulse.
4. Assert rst_n=0 asynchronously, between clock edges, during the 4th data bit of a frame.
   - tx_out=1 and tx_ready=1 before the next clock edge.
   - No tx_done pulse.
   - After release, a new 8'h81 frame transmits correctly.
5. Set CLKS_PER_BIT=1 and DATA_W=4, send 4'b1010.
   - tx_out per cycle: 0,0,1,0,1,1.
   - tx_busy for 6 cycles, tx_done on the 7th.
6. Hold tx_valid=0 for 100 cycles after reset.
   - tx_out stays at 1, tx_busy stays at 0, tx_done never asserts.
